// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 160x120 framebuffer drawing stages (fill,
// circle, future line stage).
//   SCREEN_W_DEF / SCREEN_H_DEF : default framebuffer resolution
//   colour_t                    : 3-bit pixel colour
//   circle_state_t              : circle plotter FSM states
//   octant_t                    : octant index 0..7
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef logic [2:0] colour_t;
  typedef logic [2:0] octant_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    PLOT = 2'd2,
    DONE = 2'd3
  } circle_state_t;

endpackage

// File: rtl/circle_octant.sv
// ---------------------------------------------------------------------------
// circle_octant
// Combinational mapping of one Bresenham offset pair (ox, oy) into the
// candidate pixel for a given octant, plus an on-screen test.
// Ports:
//   i_cx, i_cy   : circle centre (unsigned)
//   i_ox, i_oy   : current offsets (unsigned)
//   i_oct        : octant index 0..7
//   o_x, o_y     : candidate pixel, signed 10-bit (never wraps)
//   o_on_screen  : 1 when 0 <= x < SCREEN_W and 0 <= y < SCREEN_H
// ---------------------------------------------------------------------------
module circle_octant
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W_DEF,
  parameter int SCREEN_H = vga_pkg::SCREEN_H_DEF
) (
  input  logic [7:0]        i_cx,
  input  logic [6:0]        i_cy,
  input  logic [7:0]        i_ox,
  input  logic [7:0]        i_oy,
  input  octant_t           i_oct,
  output logic signed [9:0] o_x,
  output logic signed [9:0] o_y,
  output logic              o_on_screen
);

  // 10-bit signed holds 159+255 and 0-255 without wrapping.
  logic signed [9:0] w_cx;
  logic signed [9:0] w_cy;
  logic signed [9:0] w_ox;
  logic signed [9:0] w_oy;

  assign w_cx = $signed({2'b00, i_cx});
  assign w_cy = $signed({3'b000, i_cy});
  assign w_ox = $signed({2'b00, i_ox});
  assign w_oy = $signed({2'b00, i_oy});

  always_comb begin
    o_x = w_cx;
    o_y = w_cy;
    case (i_oct)
      3'd0: begin o_x = w_cx + w_ox; o_y = w_cy + w_oy; end
      3'd1: begin o_x = w_cx + w_oy; o_y = w_cy + w_ox; end
      3'd2: begin o_x = w_cx - w_ox; o_y = w_cy + w_oy; end
      3'd3: begin o_x = w_cx - w_oy; o_y = w_cy + w_ox; end
      3'd4: begin o_x = w_cx - w_ox; o_y = w_cy - w_oy; end
      3'd5: begin o_x = w_cx - w_oy; o_y = w_cy - w_ox; end
      3'd6: begin o_x = w_cx + w_ox; o_y = w_cy - w_oy; end
      3'd7: begin o_x = w_cx + w_oy; o_y = w_cy - w_ox; end
      default: begin o_x = w_cx; o_y = w_cy; end
    endcase
  end

  assign o_on_screen = (o_x >= 10'sd0) && (o_x < $signed(10'(SCREEN_W))) &&
                       (o_y >= 10'sd0) && (o_y < $signed(10'(SCREEN_H)));

endmodule

// File: rtl/circle.sv
// ---------------------------------------------------------------------------
// circle
// Bresenham circle plotter for the 160x120 framebuffer. Emits one candidate
// pixel per clock on the vga_adapter bus, walking octants 0..7 for every
// (ox, oy) step. Off-screen candidates are suppressed (vga_plot = 0) but
// still take their cycle.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   colour, centre_x/y,    : draw parameters, latched in INIT
//   radius
//   start                  : level request, held until done is seen
//   done                   : high while in DONE
//   vga_x, vga_y,          : pixel bus to vga_adapter; x/y/colour are 0
//   vga_colour, vga_plot     outside PLOT, plot only for on-screen pixels
// ---------------------------------------------------------------------------
module circle
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W_DEF,
  parameter int SCREEN_H = vga_pkg::SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  circle_state_t      r_state;
  logic [7:0]         r_cx;
  logic [6:0]         r_cy;
  colour_t            r_col;
  logic [7:0]         r_ox;
  logic [7:0]         r_oy;
  logic signed [10:0] r_crit;
  octant_t            r_oct;

  logic signed [9:0]  w_x;
  logic signed [9:0]  w_y;
  logic               w_on_screen;
  logic               w_in_plot;

  circle_octant #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_octant (
    .i_cx        (r_cx),
    .i_cy        (r_cy),
    .i_ox        (r_ox),
    .i_oy        (r_oy),
    .i_oct       (r_oct),
    .o_x         (w_x),
    .o_y         (w_y),
    .o_on_screen (w_on_screen)
  );

  // ---- Bresenham step, evaluated every cycle, applied on the oct=7 cycle --
  // All step arithmetic is done in 12-bit signed so that ox-1 at ox=0
  // (radius 0) goes to -1 rather than wrapping to 255; otherwise the
  // oy > ox termination test would never fire.
  logic [8:0]         w_oy_inc;
  logic signed [11:0] w_oy_inc_s;
  logic signed [11:0] w_ox_dec_s;
  logic signed [11:0] w_ox_new_s;
  logic signed [11:0] w_crit_ext;
  logic signed [11:0] w_crit_next;
  logic               w_crit_le0;
  logic               w_finish;

  assign w_oy_inc   = {1'b0, r_oy} + 9'd1;
  assign w_oy_inc_s = $signed({3'b000, w_oy_inc});
  assign w_ox_dec_s = $signed({4'b0000, r_ox}) - 12'sd1;
  assign w_crit_ext = {r_crit[10], r_crit};
  assign w_crit_le0 = r_crit[10] || (r_crit == 11'sd0);

  assign w_crit_next = w_crit_le0
                     ? w_crit_ext + (w_oy_inc_s <<< 1) + 12'sd1
                     : w_crit_ext + ((w_oy_inc_s - w_ox_dec_s) <<< 1) + 12'sd1;
  assign w_ox_new_s  = w_crit_le0 ? $signed({4'b0000, r_ox}) : w_ox_dec_s;
  assign w_finish    = w_oy_inc_s > w_ox_new_s;

  // ---- FSM -----------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_col   <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_crit  <= '0;
      r_oct   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= INIT;
          end
        end
        INIT: begin
          r_cx    <= centre_x;
          r_cy    <= centre_y;
          r_col   <= colour;
          r_ox    <= radius;
          r_oy    <= '0;
          r_crit  <= 11'sd1 - $signed({3'b000, radius});
          r_oct   <= '0;
          r_state <= PLOT;
        end
        PLOT: begin
          if (r_oct == 3'd7) begin
            r_oy   <= w_oy_inc[7:0];
            r_crit <= w_crit_next[10:0];
            if (!w_crit_le0) begin
              r_ox <= r_ox - 8'd1;
            end
            r_oct <= '0;
            if (w_finish) begin
              r_state <= DONE;
            end
          end else begin
            r_oct <= r_oct + 3'd1;
          end
        end
        DONE: begin
          if (!start) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ---- Outputs: decoded from registers only --------------------------------
  assign w_in_plot  = (r_state == PLOT);
  assign done       = (r_state == DONE);
  assign vga_plot   = w_in_plot && w_on_screen;
  assign vga_x      = w_in_plot ? w_x[7:0] : 8'd0;
  assign vga_y      = w_in_plot ? w_y[6:0] : 7'd0;
  assign vga_colour = w_in_plot ? r_col : 3'd0;

  // Upper candidate bits only matter for the on-screen test.
  logic w_unused_bits;
  assign w_unused_bits = ^{w_x[9:8], w_y[9:7], w_crit_next[11]};

endmodule

// File: doc/circle.md
# circle

Bresenham circle plotter for the 160x120 VGA framebuffer path. Takes a centre, radius and 3-bit colour, and walks the eight octants of the circle. It emits one candidate pixel per clock on the same `vga_x`/`vga_y`/`vga_colour`/`vga_plot` bus that `vga_adapter` consumes, so it drops into the top level in place of, or after, the screen-fill stage. It uses the same start/done handshake as the existing fill stage. Pixels that land off-screen are suppressed, not wrapped.

## Interface
- Parameters:
- `SCREEN_W`, 160: horizontal resolution; x valid range 0..159.
- `SCREEN_H`, 120: vertical resolution; y valid range 0..119.
- Ports:
- `clk`  in  1: system clock (CLOCK_50 at top level).
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `colour`  in  3: pixel colour, latched on start.
- `centre_x`  in  8: centre x, 0..159, latched on start.
- `centre_y`  in  7: centre y, 0..119, latched on start.
- `radius`  in  8: radius, 0..255, latched on start.
- `start`  in  1: level request. Held high until `done` is seen.
- `done`  out  1: high while in DONE.
- `vga_x`  out  8: pixel x to `vga_adapter`.
- `vga_y`  out  7: pixel y to `vga_adapter`.
- `vga_colour`  out  3: pixel colour.
- `vga_plot`  out  1: write strobe. High only for on-screen pixels.

## Operation
- States: IDLE, INIT, PLOT, DONE.
- IDLE -> INIT when `start`=1.
- INIT loads:
  - cx ← centre_x, cy ← centre_y, col ← colour.
  - ox ← radius, oy ← 0, crit ← 1 − radius.
  - oct ← 0.
  - Then goes to PLOT.
- PLOT emits one candidate per cycle, octant order oct 0..7:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx−ox, cy+oy)
  - 3: (cx−oy, cy+ox)
  - 4: (cx−ox, cy−oy)
  - 5: (cx−oy, cy−ox)
  - 6: (cx+ox, cy−oy)
  - 7: (cx+oy, cy−ox)
- On the oct=7 cycle, the step update is:
  - oy ← oy+1.
  - If crit ≤ 0: crit ← crit + 2·(oy+1) + 1.
  - Else: ox ← ox−1, crit ← crit + 2·((oy+1)−(ox−1)) + 1.
  - If new oy > new ox → DONE; else oct ← 0 and stay in PLOT.
- Duplicate points (diagonals, radius 0) are emitted as-is; no dedup.
- Clipping: candidate computed as signed 10-bit. `vga_plot` = PLOT && 0≤x<SCREEN_W && 0≤y<SCREEN_H. The cycle is spent either way.
- `crit` is signed 11-bit. ox/oy are unsigned 8-bit.
- DONE: `done`=1. DONE → IDLE when `start`=0.
- Inputs changing after INIT are ignored. `start` dropping mid-draw is ignored; the draw completes.

## Timing
- Reset (async, any state): IDLE; `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.
- Outputs are decoded from registers only. There is no combinational path from any input to any output.
- Cycle 0 = the edge at which `start`=1 is sampled in IDLE.
  - Cycle 1: INIT.
  - Cycle 2: first PLOT output (oct 0).
- A radius needing N iterations gives 8·N PLOT cycles, then `done`=1 on the following cycle.
- `done` stays high for at least 1 cycle, and until `start`=0 is sampled.
- Back-to-back draws: `start` must be seen low (IDLE) before the next request is accepted.
- `vga_x`/`vga_y` outside PLOT: hold 0; `vga_plot`=0.

## Structure
- Shared package `vga_pkg` holds:
  - `SCREEN_W`/`SCREEN_H` defaults.
  - `circle_state_t` enum (IDLE, INIT, PLOT, DONE).
  - The 3-bit colour type, reused by fill and future line stages.
- One combinational sub-module, `circle_octant`:
  - Inputs: cx, cy, ox, oy, oct.
  - Outputs: signed x/y and on-screen flag.
- The FSM and Bresenham update stay in `circle`.

## Test plan
- Centre (80,60), r=0, colour 3'b010:
  - Cycles 2..9: 8 plots, all at (80,60), colour 010.
  - `done`=1 at cycle 10.
- Centre (80,60), r=1:
  - 16 plot cycles. First 8: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
  - Next 8: (81,61)×2, (79,61)×2, (79,59)×2, (81,59)×2.
  - Then `done`.
- Centre (0,0), r=10:
  - Every strobe has x,y ≥ 0; negative candidates show `vga_plot`=0.
  - Total PLOT cycles = 8·8 = 64.
- Centre (159,119), r=255:
  - No `vga_plot` with x>159 or y>119.
  - No arithmetic wrap: no strobe at small x/y from overflow.
- Handshake and reset:
  - Hold `start` after `done`: `done` stays 1. Drop `start`: IDLE the next cycle.
  - Assert `rst_n`=0 mid-PLOT: immediately `vga_plot`=0, `done`=0.
  - Restart after reset redraws from oct 0.
